// File: rtl/rv32_isa_pkg.sv
// RV32I ALU opcodes, funct3 values and encoder FSM states shared by encoder and decoders.
// The FILL state exists only when ENCODER_NOP_FILL_EN is defined.
package rv32_isa_pkg;

  localparam logic [6:0]  OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0]  OPCODE_OP     = 7'h33;
  localparam logic [31:0] NOP           = 32'h00000013;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READY,
    ST_WRITE
`ifdef ENCODER_NOP_FILL_EN
    , ST_FILL
`endif
  } enc_state_e;

endpackage

// File: rtl/rv32_alu_insn_pack.sv
// Combinational packer: decoded ALU fields -> RV32I word plus an illegal-combination flag.
module rv32_alu_insn_pack
  import rv32_isa_pkg::*;
(
  input  logic        fmt,
  input  logic        sub_sra,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    if (fmt) begin
      illegal = sub_sra && !(funct3 == F3_ADD || funct3 == F3_SR);
      word    = {1'b0, sub_sra, 5'b0, rs2, rs1, funct3, rd, OPCODE_OP};
    end else begin
      illegal = sub_sra && (funct3 != F3_SR);
      // shifts carry only a 5-bit shamt; the upper immediate bits hold funct7
      if (funct3 == F3_SLL || funct3 == F3_SR)
        word = {1'b0, sub_sra, 5'b0, imm[4:0], rs1, funct3, rd, OPCODE_OP_IMM};
      else
        word = {imm, rs1, funct3, rd, OPCODE_OP_IMM};
    end
  end

endmodule

// File: rtl/rv32_alu_insn_encoder.sv
// RV32I ALU instruction encoder: accepts field bundles and writes packed words to IMEM via we/ack.
// Define ENCODER_NOP_FILL_EN to pad the remaining words with NOPs after finish.
module rv32_alu_insn_encoder
  import rv32_isa_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          fmt,
  input  logic          sub_sra,
  input  logic [2:0]    funct3,
  input  logic [4:0]    rd,
  input  logic [4:0]    rs1,
  input  logic [4:0]    rs2,
  input  logic [11:0]   imm,
  input  logic          finish,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  output logic [AW:0]   insn_count,
  output logic          full,
  output logic          busy,
  output logic          err
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  enc_state_e  state;
  logic        finish_pend;
  logic [31:0] pack_word;
  logic        pack_illegal;
  logic [AW:0] count_inc;
  logic        full_after;
  logic        start_ok;
  logic        accept;

  rv32_alu_insn_pack u_pack (
    .fmt     (fmt),
    .sub_sra (sub_sra),
    .funct3  (funct3),
    .rd      (rd),
    .rs1     (rs1),
    .rs2     (rs2),
    .imm     (imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign count_inc  = insn_count + (AW+1)'(1);
  assign full_after = (count_inc == DEPTH_C);
  assign start_ok   = start && (state == ST_IDLE || state == ST_READY);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      finish_pend <= 1'b0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      insn_count  <= '0;
      full        <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (start_ok) begin
        state       <= ST_READY;
        mem_addr    <= base_addr;
        insn_count  <= '0;
        full        <= 1'b0;
        finish_pend <= 1'b0;
        in_ready    <= 1'b1;
        busy        <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_READY: begin
            if (accept) begin
              if (finish) finish_pend <= 1'b1;
              if (pack_illegal) begin
                err <= 1'b1;
              end else begin
                state     <= ST_WRITE;
                mem_we    <= 1'b1;
                mem_wdata <= pack_word;
                in_ready  <= 1'b0;
              end
            end else if (finish || finish_pend) begin
              finish_pend <= 1'b0;
              in_ready    <= 1'b0;
`ifdef ENCODER_NOP_FILL_EN
              if (full) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state     <= ST_FILL;
                mem_we    <= 1'b1;
                mem_wdata <= NOP;
              end
`else
              state <= ST_IDLE;
              busy  <= 1'b0;
`endif
            end
          end
          ST_WRITE: begin
            if (mem_ack) begin
              mem_addr   <= mem_addr + AW'(1);
              insn_count <= count_inc;
              full       <= full_after;
              if (finish_pend || finish) begin
                finish_pend <= 1'b0;
`ifdef ENCODER_NOP_FILL_EN
                if (full_after) begin
                  state  <= ST_IDLE;
                  mem_we <= 1'b0;
                  busy   <= 1'b0;
                end else begin
                  state     <= ST_FILL;
                  mem_wdata <= NOP;
                end
`else
                state  <= ST_IDLE;
                mem_we <= 1'b0;
                busy   <= 1'b0;
`endif
              end else begin
                state    <= ST_READY;
                mem_we   <= 1'b0;
                in_ready <= !full_after;
              end
            end else if (finish) begin
              finish_pend <= 1'b1;
            end
          end
`ifdef ENCODER_NOP_FILL_EN
          ST_FILL: begin
            if (mem_ack) begin
              mem_addr   <= mem_addr + AW'(1);
              insn_count <= count_inc;
              full       <= full_after;
              if (full_after) begin
                state  <= ST_IDLE;
                mem_we <= 1'b0;
                busy   <= 1'b0;
              end
            end
          end
`endif
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
